// File: rtl/stream_mult_driver.sv
// Initiator for a bit-serial streaming multiplier: serialises two operands LSB-first
// (zero-padded to 2*WIDTH bits) and reassembles the returned product stream.
module stream_mult_driver #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [2*WIDTH-1:0] product,
  output logic               ser_a,
  output logic               ser_b,
  output logic               ser_valid,
  output logic               ser_first,
  input  logic               res_bit,
  input  logic               res_valid
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(PW + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST  = CW'(PW - 1);
  localparam logic [CW-1:0] FULL  = CW'(PW);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] sh_a, sh_a_d, sh_b, sh_b_d;
  logic [CW-1:0]    scnt, scnt_d, rcnt, rcnt_d;
  logic [TW-1:0]    tcnt, tcnt_d;
  logic [PW-1:0]    cap, cap_d, product_d;
  logic             busy_d, done_d, err_d;
  logic             ser_a_d, ser_b_d, ser_valid_d, ser_first_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d     = state;
    sh_a_d      = sh_a;
    sh_b_d      = sh_b;
    scnt_d      = scnt;
    rcnt_d      = rcnt;
    tcnt_d      = tcnt;
    cap_d       = cap;
    product_d   = product;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    ser_a_d     = 1'b0;
    ser_b_d     = 1'b0;
    ser_valid_d = 1'b0;
    ser_first_d = 1'b0;

    // Result bits enter at the MSB so the first bit received ends up at bit 0.
    if (state != IDLE && res_valid && rcnt != FULL) begin
      cap_d  = {res_bit, cap[PW-1:1]};
      rcnt_d = rcnt + 1'b1;
    end

    // Output registers are loaded with the values for the coming cycle,
    // so the serial bit for scnt=k is prepared on the edge that enters k.
    case (state)
      IDLE: begin
        if (start) begin
          state_d     = STREAM;
          sh_a_d      = a >> 1;
          sh_b_d      = b >> 1;
          scnt_d      = '0;
          rcnt_d      = '0;
          tcnt_d      = '0;
          cap_d       = '0;
          ser_a_d     = a[0];
          ser_b_d     = b[0];
          ser_valid_d = 1'b1;
          ser_first_d = 1'b1;
          busy_d      = 1'b1;
        end
      end
      STREAM: begin
        if (rcnt == FULL) begin
          state_d   = IDLE;
          product_d = cap;
          done_d    = 1'b1;
        end else begin
          busy_d = 1'b1;
          scnt_d = scnt + 1'b1;
          sh_a_d = sh_a >> 1;
          sh_b_d = sh_b >> 1;
          if (scnt == LAST) begin
            state_d = DRAIN;
          end else begin
            ser_valid_d = 1'b1;
            ser_a_d     = sh_a[0];
            ser_b_d     = sh_b[0];
          end
        end
      end
      DRAIN: begin
        busy_d = 1'b1;
        if (rcnt == FULL) begin
          state_d   = IDLE;
          product_d = cap;
          done_d    = 1'b1;
          busy_d    = 1'b0;
        end else if (res_valid) begin
          tcnt_d = '0;
        end else if (tcnt == TLAST) begin
          state_d = IDLE;
          err_d   = 1'b1;
          busy_d  = 1'b0;
          tcnt_d  = '0;
        end else begin
          tcnt_d = tcnt + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_a      <= '0;
      sh_b      <= '0;
      scnt      <= '0;
      rcnt      <= '0;
      tcnt      <= '0;
      cap       <= '0;
      product   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      ser_a     <= 1'b0;
      ser_b     <= 1'b0;
      ser_valid <= 1'b0;
      ser_first <= 1'b0;
    end else begin
      sh_a      <= sh_a_d;
      sh_b      <= sh_b_d;
      scnt      <= scnt_d;
      rcnt      <= rcnt_d;
      tcnt      <= tcnt_d;
      cap       <= cap_d;
      product   <= product_d;
      busy      <= busy_d;
      done      <= done_d;
      err       <= err_d;
      ser_a     <= ser_a_d;
      ser_b     <= ser_b_d;
      ser_valid <= ser_valid_d;
      ser_first <= ser_first_d;
    end
  end

endmodule

// File: tb/tb_stream_mult_driver.sv
// Self-checking bench for stream_mult_driver with a behavioural serial multiplier
// (3-cycle latency, zero latency, or silent) and a table of directed vectors.
module tb_stream_mult_driver;
  localparam int W  = 8;
  localparam int PW = 16;
  localparam int TO = 64;

  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [W-1:0]  a = '0, b = '0;
  logic          busy, done, err;
  logic [PW-1:0] product;
  logic          ser_a, ser_b, ser_valid, ser_first;
  logic          res_bit = 1'b0, res_valid = 1'b0;

  always #5 clk = ~clk;

  stream_mult_driver #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .err(err), .product(product),
    .ser_a(ser_a), .ser_b(ser_b), .ser_valid(ser_valid), .ser_first(ser_first),
    .res_bit(res_bit), .res_valid(res_valid)
  );

  int errors = 0;
  int checks = 0;
  int mode   = 0;  // 0: 3-cycle latency core, 1: zero-latency core, 2: core never answers

  // Behavioural multiplier: bit k of a*b depends only on operand bits 0..k.
  logic [PW-1:0]   m_acc_a, m_acc_b;
  logic [2*PW-1:0] m_full;
  int              m_k;
  bit              m_pv[3], m_pb[3];
  bit              m_cur_v, m_cur_b;

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      m_k = 0; m_acc_a = '0; m_acc_b = '0;
      for (int i = 0; i < 3; i++) begin m_pv[i] = 0; m_pb[i] = 0; end
      res_valid = 1'b0; res_bit = 1'b0;
    end else begin
      m_cur_v = 0; m_cur_b = 0;
      if (ser_valid) begin
        if (ser_first) begin m_k = 0; m_acc_a = '0; m_acc_b = '0; end
        if (m_k < PW) begin
          m_acc_a[m_k] = ser_a;
          m_acc_b[m_k] = ser_b;
          m_full  = m_acc_a * m_acc_b;
          m_cur_b = m_full[m_k];
          m_cur_v = 1;
          m_k++;
        end
      end
      case (mode)
        0: begin
          res_valid = m_pv[2]; res_bit = m_pb[2];
          m_pv[2] = m_pv[1]; m_pb[2] = m_pb[1];
          m_pv[1] = m_pv[0]; m_pb[1] = m_pb[0];
          m_pv[0] = m_cur_v; m_pb[0] = m_cur_b;
        end
        1: begin res_valid = m_cur_v; res_bit = m_cur_b; end
        default: begin res_valid = 1'b0; res_bit = 1'b0; end
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Results of the last transaction
  int            r_done, r_err, r_done_c, r_err_c, r_nv, r_nf, r_first_bad, r_busy_bad;
  logic [PW-1:0] r_fa, r_fb;

  task automatic run_txn(input logic [W-1:0] ta, input logic [W-1:0] tb, input bit extra);
    int  tail;
    bit  prev_busy;
    tail = extra ? 30 : 3;
    r_done = 0; r_err = 0; r_done_c = -1; r_err_c = -1;
    r_nv = 0; r_nf = 0; r_first_bad = 0; r_busy_bad = 0; r_fa = '0; r_fb = '0;
    prev_busy = 0;
    @(negedge clk); a = ta; b = tb; start = 1'b1;
    @(negedge clk); start = 1'b0;
    // c counts cycles from the first STREAM cycle
    for (int c = 0; c < 200; c++) begin
      start = extra && (c == 2 || c == 10);
      if (ser_valid) begin
        if (r_nv < PW) begin r_fa[r_nv] = ser_a; r_fb[r_nv] = ser_b; end
        if (ser_first) begin r_nf++; if (r_nv != 0) r_first_bad++; end
        r_nv++;
      end else if (ser_first) begin
        r_first_bad++;
      end
      if (done) begin
        r_done++;
        if (r_done_c < 0) r_done_c = c;
        if (busy || !prev_busy) r_busy_bad++;
      end
      if (err) begin
        r_err++;
        if (r_err_c < 0) r_err_c = c;
      end
      if ((r_done_c >= 0 && c >= r_done_c + tail) || (r_err_c >= 0 && c >= r_err_c + tail)) break;
      prev_busy = busy;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  typedef struct {
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [PW-1:0] p;
  } vec_t;

  vec_t tbl[7];
  logic [W-1:0] ra, rb;

  initial begin
    tbl[0] = '{a: 8'd3,   b: 8'd5,   p: 16'd15};
    tbl[1] = '{a: 8'd255, b: 8'd255, p: 16'hFE01};
    tbl[2] = '{a: 8'd0,   b: 8'd200, p: 16'd0};
    tbl[3] = '{a: 8'd7,   b: 8'd9,   p: 16'd63};
    tbl[4] = '{a: 8'd1,   b: 8'd255, p: 16'd255};
    tbl[5] = '{a: 8'd128, b: 8'd128, p: 16'h4000};
    tbl[6] = '{a: 8'd170, b: 8'd85,  p: 16'd14450};

    #12;
    chk("reset_outputs", {busy, done, err, ser_a, ser_b, ser_valid, ser_first}, 0);
    chk("reset_product", product, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);

    mode = 0;
    foreach (tbl[i]) begin
      run_txn(tbl[i].a, tbl[i].b, 0);
      chk($sformatf("v%0d_product", i), product, tbl[i].p);
      chk($sformatf("v%0d_done_cnt", i), r_done, 1);
      chk($sformatf("v%0d_done_cycle", i), r_done_c, 20);
      chk($sformatf("v%0d_err_cnt", i), r_err, 0);
      chk($sformatf("v%0d_busy_at_done", i), r_busy_bad, 0);
      chk($sformatf("v%0d_frame_a", i), r_fa, {8'd0, tbl[i].a});
      chk($sformatf("v%0d_frame_b", i), r_fb, {8'd0, tbl[i].b});
      chk($sformatf("v%0d_valid_cnt", i), r_nv, PW);
      chk($sformatf("v%0d_first", i), {r_nf[15:0], r_first_bad[15:0]}, {16'd1, 16'd0});
    end

    // Timeout with the previous product left intact
    run_txn(8'd255, 8'd255, 0);
    chk("pre_timeout_product", product, 16'hFE01);
    mode = 2;
    run_txn(8'd1, 8'd1, 0);
    chk("timeout_err_cnt", r_err, 1);
    chk("timeout_err_cycle", r_err_c, 16 + TO);
    chk("timeout_done_cnt", r_done, 0);
    chk("timeout_product", product, 16'hFE01);
    chk("timeout_busy", busy, 0);

    // start while busy is ignored
    mode = 0;
    run_txn(8'd3, 8'd5, 1);
    chk("busy_start_frame_a", r_fa, 16'h0003);
    chk("busy_start_valid_cnt", r_nv, PW);
    chk("busy_start_first", r_nf, 1);
    chk("busy_start_done_cnt", r_done, 1);
    chk("busy_start_product", product, 16'd15);

    // Asynchronous reset at STREAM cycle 5
    @(negedge clk); a = 8'hAA; b = 8'h55; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_reset_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_outputs", {busy, done, err, ser_a, ser_b, ser_valid, ser_first}, 0);
    chk("midreset_product", product, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("post_reset_quiet", {busy, done, err, ser_valid}, 0);
    end
    run_txn(8'd7, 8'd9, 0);
    chk("post_reset_product", product, 16'd63);
    chk("post_reset_done_cnt", r_done, 1);

    // Zero-latency core with random operands
    mode = 1;
    for (int n = 0; n < 20; n++) begin
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(0, 255));
      run_txn(ra, rb, 0);
      chk($sformatf("zl%0d_product", n), product, 32'(ra) * 32'(rb));
      chk($sformatf("zl%0d_done", n), {r_done[15:0], r_err[15:0]}, {16'd1, 16'd0});
      chk($sformatf("zl%0d_done_cycle", n), r_done_c, 17);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
